// File: rtl/mem_bus_responder.sv
// Single-cycle CPU bus responder: byte RAM, TX FIFO toward a UART, RX holding
// register, free-running cycle counter with a readable snapshot, and halt flag.
module mem_bus_responder #(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] bus_a,
  input  logic        bus_wr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        sys_halt,
  output logic        tx_overflow
);

  localparam int PTR_W     = $clog2(TX_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int RAM_BYTES = 1 << RAM_ADDR_W;

  localparam logic [15:0] IO_TX_RX  = 16'h0000;
  localparam logic [15:0] IO_CNT_B0 = 16'h0004;
  localparam logic [15:0] IO_CNT_B1 = 16'h0005;
  localparam logic [15:0] IO_CNT_B2 = 16'h0006;
  localparam logic [15:0] IO_CNT_B3 = 16'h0007;

  // ---------------------------------------------------------------------------
  // Address decode (only bits 17:0 take part)
  // ---------------------------------------------------------------------------
  logic [17:0]           dec_a;
  logic                  is_io;
  logic                  is_ram;
  logic                  io_tx_rx;
  logic                  io_cnt_b0;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic                  unused_bus_bits;

  assign dec_a           = bus_a[17:0];
  assign is_io           = (dec_a[17:16] == 2'b11);
  assign is_ram          = (dec_a[17] == 1'b0);
  assign io_tx_rx        = is_io && (dec_a[15:0] == IO_TX_RX);
  assign io_cnt_b0       = is_io && (dec_a[15:0] == IO_CNT_B0);
  assign ram_addr        = bus_a[RAM_ADDR_W-1:0];
  assign unused_bus_bits = ^bus_a[31:18];

  logic rd_en;
  logic wr_en;

  assign rd_en = !bus_wr;
  // Once halted, every write (RAM or IO) is dropped.
  assign wr_en = bus_wr && !sys_halt;

  // ---------------------------------------------------------------------------
  // RAM: synchronous write, registered read, no reset on the array
  // ---------------------------------------------------------------------------
  logic [7:0] ram [RAM_BYTES];
  logic [7:0] ram_q;
  logic       ram_we;

  assign ram_we = wr_en && is_ram;

  always_ff @(posedge clk_in) begin
    if (ram_we) begin
      ram[ram_addr] <= bus_wdata;
    end
    ram_q <= ram[ram_addr];
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // Handshake: a byte leaves the FIFO on every rising edge where tx_valid and
  // tx_ready are both high; tx_data is the head and is stable while tx_valid
  // is high and tx_ready is low.
  // ---------------------------------------------------------------------------
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic [7:0]       push_byte;

  assign fifo_full = (count == CNT_W'(TX_DEPTH));
  assign pop       = tx_valid && tx_ready;
  // The halt register emits a 0x00 marker even though zero data is otherwise dropped.
  assign push_req  = wr_en && ((io_tx_rx && (bus_wdata != 8'h00)) || io_cnt_b0);
  assign push_byte = io_cnt_b0 ? 8'h00 : bus_wdata;
  // A full FIFO still accepts a push when the head is leaving in the same cycle.
  assign push_ok   = push_req && (!fifo_full || pop);

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      tx_mem[wr_ptr] <= push_byte;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) begin
        tx_overflow <= 1'b1;
      end
    end
  end

  assign tx_valid       = (count != '0);
  assign tx_data        = tx_mem[rd_ptr];
  assign io_buffer_full = (count >= CNT_W'(TX_DEPTH - 1));

  // ---------------------------------------------------------------------------
  // Halt flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sys_halt <= 1'b0;
    end else if (wr_en && io_cnt_b0) begin
      sys_halt <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // RX holding register: a new byte always wins over the read-clear
  // ---------------------------------------------------------------------------
  logic [7:0] rx_byte;
  logic       rx_full;
  logic       rx_take;

  assign rx_take = rd_en && io_tx_rx;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_byte <= 8'h00;
      rx_full <= 1'b0;
    end else begin
      if (rx_valid) begin
        rx_byte <= rx_data;
        rx_full <= 1'b1;
      end else if (rx_take) begin
        rx_full <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle counter and read snapshot
  // ---------------------------------------------------------------------------
  logic [31:0] cycle_cnt;
  logic [31:0] cnt_latch;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_cnt <= 32'd0;
      cnt_latch <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (rd_en && io_cnt_b0) begin
        cnt_latch <= cycle_cnt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read data path: IO bytes and the RAM output are registered separately and
  // selected by a registered flag, so the RAM array itself needs no reset.
  // ---------------------------------------------------------------------------
  logic [7:0] io_rd_next;
  logic [7:0] io_rd_q;
  logic       rd_sel_ram;

  always_comb begin
    io_rd_next = 8'h00;
    if (rd_en && is_io) begin
      case (dec_a[15:0])
        IO_TX_RX:  io_rd_next = rx_full ? rx_byte : 8'h00;
        IO_CNT_B0: io_rd_next = cycle_cnt[7:0];
        IO_CNT_B1: io_rd_next = cnt_latch[15:8];
        IO_CNT_B2: io_rd_next = cnt_latch[23:16];
        IO_CNT_B3: io_rd_next = cnt_latch[31:24];
        default:   io_rd_next = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      io_rd_q    <= 8'h00;
      rd_sel_ram <= 1'b0;
    end else begin
      io_rd_q    <= io_rd_next;
      rd_sel_ram <= rd_en && is_ram;
    end
  end

  assign bus_rdata = rd_sel_ram ? ram_q : io_rd_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: queue/array reference model checked every
// falling edge, plus directed sequences with literal expected values.
module tb_mem_bus_responder;

  localparam int DEPTH = 8;
  localparam logic [31:0] IDLE_A = 32'h0002_0000;

  // ---------------- clock / reset ----------------
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] bus_a;
  logic        bus_wr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        sys_halt;
  logic        tx_overflow;

  always #5 clk_in = ~clk_in;

  mem_bus_responder #(.RAM_ADDR_W(17), .TX_DEPTH(DEPTH)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .bus_a          (bus_a),
    .bus_wr         (bus_wr),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .sys_halt       (sys_halt),
    .tx_overflow    (tx_overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  exp_q[$];
  logic [7:0]  m_ram [int];
  logic        m_halt = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_rx_full = 1'b0;
  logic [7:0]  m_rx_byte = 8'h00;
  logic [31:0] m_cnt = 32'd0;
  logic [31:0] m_latch = 32'd0;
  logic [7:0]  m_rdata = 8'h00;
  logic        m_rdata_known = 1'b1;

  task automatic model_step();
    logic [17:0] a;
    bit          pop;
    bit          push;
    logic [7:0]  pb;
    a    = bus_a[17:0];
    pop  = (exp_q.size() != 0) && tx_ready;
    push = 0;
    pb   = 8'h00;
    if (!bus_wr) begin
      m_rdata_known = 1'b1;
      m_rdata       = 8'h00;
      if (a[17:16] == 2'b11) begin
        if (a[15:0] == 16'h0000) begin
          m_rdata   = m_rx_full ? m_rx_byte : 8'h00;
          m_rx_full = 1'b0;
        end else if (a[15:0] == 16'h0004) begin
          m_latch = m_cnt;
          m_rdata = m_cnt[7:0];
        end else if (a[15:0] == 16'h0005) m_rdata = m_latch[15:8];
        else if (a[15:0] == 16'h0006) m_rdata = m_latch[23:16];
        else if (a[15:0] == 16'h0007) m_rdata = m_latch[31:24];
      end else if (a[17] == 1'b0) begin
        if (m_ram.exists(int'(a[16:0]))) m_rdata = m_ram[int'(a[16:0])];
        else m_rdata_known = 1'b0;
      end
    end else begin
      m_rdata_known = 1'b0;
      if (!m_halt) begin
        if (a[17] == 1'b0) m_ram[int'(a[16:0])] = bus_wdata;
        else if (a == 18'h30000 && bus_wdata != 8'h00) begin
          push = 1;
          pb   = bus_wdata;
        end else if (a == 18'h30004) begin
          push   = 1;
          m_halt = 1'b1;
        end
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(pb);
      else m_ovf = 1'b1;
    end
    if (rx_valid) begin
      m_rx_byte = rx_data;
      m_rx_full = 1'b1;
    end
    m_cnt = m_cnt + 32'd1;
  endtask

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      exp_q.delete();
      m_halt        = 1'b0;
      m_ovf         = 1'b0;
      m_rx_full     = 1'b0;
      m_rx_byte     = 8'h00;
      m_cnt         = 32'd0;
      m_latch       = 32'd0;
      m_rdata       = 8'h00;
      m_rdata_known = 1'b1;
    end else begin
      model_step();
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk_in) begin
    check("tx_valid", {31'd0, tx_valid}, {31'd0, exp_q.size() != 0});
    check("io_buffer_full", {31'd0, io_buffer_full}, {31'd0, exp_q.size() >= DEPTH - 1});
    check("sys_halt", {31'd0, sys_halt}, {31'd0, m_halt});
    check("tx_overflow", {31'd0, tx_overflow}, {31'd0, m_ovf});
    if (exp_q.size() != 0) check("tx_data", {24'd0, tx_data}, {24'd0, exp_q[0]});
    if (m_rdata_known) check("bus_rdata", {24'd0, bus_rdata}, {24'd0, m_rdata});
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; presents one bus cycle, returns at the next posedge+1.
  task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
    bus_wr    = wr;
    bus_a     = a;
    bus_wdata = d;
    @(posedge clk_in);
    #1;
    bus_wr    = 1'b0;
    bus_a     = IDLE_A;
    bus_wdata = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, IDLE_A, 8'h00);
  endtask

  // ---------------- directed stimulus ----------------
  logic [7:0] drain_exp [8];
  logic [7:0] drained   [$];

  initial begin
    drain_exp = '{8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h5A};
    bus_a     = IDLE_A;
    bus_wr    = 1'b0;
    bus_wdata = 8'h00;
    tx_ready  = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;

    repeat (3) @(posedge clk_in);
    #1;
    check("rst_bus_rdata", {24'd0, bus_rdata}, 32'h0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
    check("rst_io_full", {31'd0, io_buffer_full}, 32'h0);
    check("rst_halt", {31'd0, sys_halt}, 32'h0);
    check("rst_overflow", {31'd0, tx_overflow}, 32'h0);
    rst_in = 1'b1;
    idle(1);

    // RAM write then read in the next cycle, address aliasing, top address
    drive(1'b1, 32'h0000_0010, 8'hA5);
    drive(1'b0, 32'h0000_0010, 8'h00);
    check("ram_readback", {24'd0, bus_rdata}, 32'hA5);
    drive(1'b1, 32'hFFF4_0020, 8'h3C);
    drive(1'b0, 32'h0000_0020, 8'h00);
    check("ram_high_bits_ignored", {24'd0, bus_rdata}, 32'h3C);
    drive(1'b1, 32'h0001_FFFF, 8'h5A);
    drive(1'b0, 32'h0001_FFFF, 8'h00);
    check("ram_top_byte", {24'd0, bus_rdata}, 32'h5A);

    // unmapped region and unused IO addresses
    drive(1'b1, 32'h0002_0010, 8'h77);
    drive(1'b0, 32'h0002_0010, 8'h00);
    check("unmapped_read", {24'd0, bus_rdata}, 32'h0);
    drive(1'b1, 32'h0003_0008, 8'h66);
    drive(1'b0, 32'h0003_0008, 8'h00);
    check("io_other_read", {24'd0, bus_rdata}, 32'h0);

    // RX holding register
    rx_valid = 1'b1; rx_data = 8'h41;
    idle(1);
    rx_valid = 1'b0;
    drive(1'b0, 32'h0003_0000, 8'h00);
    check("rx_first_read", {24'd0, bus_rdata}, 32'h41);
    drive(1'b0, 32'h0003_0000, 8'h00);
    check("rx_empty_read", {24'd0, bus_rdata}, 32'h0);
    rx_valid = 1'b1; rx_data = 8'h55;
    idle(1);
    rx_data = 8'h66;
    drive(1'b0, 32'h0003_0000, 8'h00);
    rx_valid = 1'b0;
    check("rx_same_cycle_old", {24'd0, bus_rdata}, 32'h55);
    drive(1'b0, 32'h0003_0000, 8'h00);
    check("rx_same_cycle_new", {24'd0, bus_rdata}, 32'h66);

    // counter snapshot at 0x304
    for (int i = 0; i < 2000 && m_cnt != 32'h304; i++) idle(1);
    if (m_cnt != 32'h304) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cnt_wait: got %h expected %h", m_cnt, 32'h304);
    end
    drive(1'b0, 32'h0003_0004, 8'h00);
    check("cnt_byte0", {24'd0, bus_rdata}, 32'h04);
    drive(1'b0, 32'h0003_0005, 8'h00);
    check("cnt_byte1", {24'd0, bus_rdata}, 32'h03);
    drive(1'b0, 32'h0003_0006, 8'h00);
    check("cnt_byte2", {24'd0, bus_rdata}, 32'h00);
    drive(1'b0, 32'h0003_0007, 8'h00);
    check("cnt_byte3", {24'd0, bus_rdata}, 32'h00);
    idle(5);
    drive(1'b0, 32'h0003_0005, 8'h00);
    check("cnt_latch_held", {24'd0, bus_rdata}, 32'h03);

    // TX FIFO fill with no drain: zero skipped, near-full at 7, overflow on 9th
    tx_ready = 1'b0;
    drive(1'b1, 32'h0003_0000, 8'h48);
    drive(1'b1, 32'h0003_0000, 8'h69);
    drive(1'b1, 32'h0003_0000, 8'h00);
    check("tx_head_H", {24'd0, tx_data}, 32'h48);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h0003_0000, 8'h61 + 8'(i));
    check("io_full_at_6", {31'd0, io_buffer_full}, 32'h0);
    drive(1'b1, 32'h0003_0000, 8'h65);
    check("io_full_at_7", {31'd0, io_buffer_full}, 32'h1);
    drive(1'b1, 32'h0003_0000, 8'h66);
    check("no_overflow_at_8", {31'd0, tx_overflow}, 32'h0);
    drive(1'b1, 32'h0003_0000, 8'h67);
    check("overflow_on_9th", {31'd0, tx_overflow}, 32'h1);
    check("head_kept_after_drop", {24'd0, tx_data}, 32'h48);

    // asynchronous reset discards the queue at once
    rst_in = 1'b0;
    #1;
    check("async_clear_valid", {31'd0, tx_valid}, 32'h0);
    check("async_clear_full", {31'd0, io_buffer_full}, 32'h0);
    check("async_clear_ovf", {31'd0, tx_overflow}, 32'h0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    idle(1);
    drive(1'b0, 32'h0000_0010, 8'h00);
    check("ram_survives_reset", {24'd0, bus_rdata}, 32'hA5);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h0003_0000, 8'h31 + 8'(i));
    check("full_again", {31'd0, io_buffer_full}, 32'h1);
    tx_ready = 1'b1;
    drive(1'b1, 32'h0003_0000, 8'h5A);
    check("pushpop_full_ovf", {31'd0, tx_overflow}, 32'h0);
    check("pushpop_full_head", {24'd0, tx_data}, 32'h32);
    for (int i = 0; i < 20 && tx_valid; i++) begin
      drained.push_back(tx_data);
      idle(1);
    end
    check("drain_count", drained.size(), 32'd8);
    for (int i = 0; i < 8 && i < drained.size(); i++)
      check("drain_order", {24'd0, drained[i]}, {24'd0, drain_exp[i]});

    // halt: 0x00 marker queued, later writes dropped
    tx_ready = 1'b0;
    drive(1'b1, 32'h0003_0004, 8'h99);
    check("halt_set", {31'd0, sys_halt}, 32'h1);
    check("halt_marker_valid", {31'd0, tx_valid}, 32'h1);
    check("halt_marker_data", {24'd0, tx_data}, 32'h00);
    drive(1'b1, 32'h0000_0010, 8'h11);
    drive(1'b0, 32'h0000_0010, 8'h00);
    check("ram_write_after_halt", {24'd0, bus_rdata}, 32'hA5);
    drive(1'b1, 32'h0003_0000, 8'h51);
    tx_ready = 1'b1;
    idle(1);
    check("io_write_after_halt", {31'd0, tx_valid}, 32'h0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
